// File: rtl/sha_pkg.sv
// Shared SHA-256 types and constants used by the message padder and the compression stage.
package sha_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0][31:0] block_t;

  typedef enum logic [1:0] {StFill, StMark, StZpad, StEmit} pad_state_e;

  localparam word_t PAD_MARK = 32'h8000_0000;

  localparam word_t SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Keep bytes 0..nbytes-1, place the 0x80 marker at byte nbytes, zero the rest.
  function automatic word_t pad_word(input word_t data, input logic [2:0] nbytes);
    word_t w;
    w = data;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(nbytes)) w[31-8*i -: 8] = 8'h80;
      else if (i > int'(nbytes)) w[31-8*i -: 8] = 8'h00;
    end
    return w;
  endfunction

endpackage

// File: rtl/sha_msg_pad.sv
// SHA-256 message padder: packs 32-bit words into padded 512-bit blocks with first/last tags.
// Optional protocol checking is built when SHA_PAD_CHK_EN is defined.
module sha_msg_pad
  import sha_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_w,
  output logic         blk_first,
  output logic         blk_last,
  output logic         err
);

  pad_state_e       state_q, state_d, resume_q, resume_d;
  block_t           buf_q, buf_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] bitlen_q, bitlen_d, add_amt;
  logic             first_pend_q, first_pend_d;
  logic             blk_valid_q, blk_valid_d, blk_first_q, blk_first_d, blk_last_q, blk_last_d;
  logic             xfer, len_clr, emit, emit_last;
  pad_state_e       emit_resume;
  logic [2:0]       nbytes;
  logic [3:0]       slot;
  logic [63:0]      len64;

  assign in_ready  = (state_q == StFill) && !blk_valid_q;
  assign xfer      = in_valid && in_ready;
  assign nbytes    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign slot      = 4'd15 - widx_q;  // W0 lives in the top word of the packed block
  assign len64     = 64'(bitlen_q);
  assign add_amt   = !xfer ? '0 : in_last ? LEN_W'({nbytes, 3'b000}) : LEN_W'(32);
  assign blk_valid = blk_valid_q;
  assign blk_w     = buf_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    buf_d        = buf_q;
    widx_d       = widx_q;
    first_pend_d = first_pend_q;
    blk_valid_d  = blk_valid_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    len_clr      = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_resume  = StFill;
    unique case (state_q)
      StFill: begin
        if (xfer) begin
          buf_d[slot] = in_last ? pad_word(in_data, nbytes) : in_data;
          emit_resume = !in_last ? StFill : (nbytes == 3'd4) ? StMark : StZpad;
          if (widx_q == 4'd15) emit = 1'b1;
          else begin
            widx_d  = widx_q + 4'd1;
            state_d = emit_resume;
          end
        end
      end
      StMark: begin
        buf_d[slot] = PAD_MARK;
        emit_resume = StZpad;
        if (widx_q == 4'd15) emit = 1'b1;
        else begin
          widx_d  = widx_q + 4'd1;
          state_d = StZpad;
        end
      end
      StZpad: begin
        if (widx_q == 4'd14) begin
          buf_d[1]    = len64[63:32];
          buf_d[0]    = len64[31:0];
          emit        = 1'b1;
          emit_last   = 1'b1;
          emit_resume = StFill;
        end else if (widx_q == 4'd15) begin
          // Marker sat in W14/W15: no room for the length, so a second block follows.
          buf_d[0]    = '0;
          emit        = 1'b1;
          emit_resume = StZpad;
        end else begin
          buf_d[slot] = '0;
          widx_d      = widx_q + 4'd1;
        end
      end
      StEmit: begin
        if (blk_ready) begin
          blk_valid_d  = 1'b0;
          first_pend_d = 1'b0;
          state_d      = resume_q;
          if (blk_last_q) begin
            len_clr      = 1'b1;
            first_pend_d = 1'b1;
            state_d      = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
    if (emit) begin
      blk_valid_d = 1'b1;
      blk_first_d = first_pend_q;
      blk_last_d  = emit_last;
      widx_d      = 4'd0;
      resume_d    = emit_resume;
      state_d     = StEmit;
    end
    bitlen_d = len_clr ? '0 : bitlen_q + add_amt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFill;
      resume_q     <= StFill;
      buf_q        <= '0;
      widx_q       <= 4'd0;
      bitlen_q     <= '0;
      first_pend_q <= 1'b1;
      blk_valid_q  <= 1'b0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      buf_q        <= buf_d;
      widx_q       <= widx_d;
      bitlen_q     <= bitlen_d;
      first_pend_q <= first_pend_d;
      blk_valid_q  <= blk_valid_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
    end
  end

`ifdef SHA_PAD_CHK_EN
  logic             err_q, ovf_q;
  logic [LEN_W:0]   sum_ext;

  assign sum_ext = {1'b0, bitlen_q} + {1'b0, add_amt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (xfer && in_last && (in_bytes > 3'd4)) err_q <= 1'b1;
      if (blk_valid_q && blk_first_q && blk_last_q && ovf_q) err_q <= 1'b1;
      if (len_clr) ovf_q <= 1'b0;
      else if (sum_ext[LEN_W]) ovf_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha_msg_pad.sv
// Directed self-checking bench for sha_msg_pad.
module tb_sha_msg_pad;
  import sha_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         blk_valid, blk_ready, blk_first, blk_last, err;
  logic [511:0] blk_w;

  int vectors = 0;
  int miscompares = 0;

  sha_msg_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_w     (blk_w),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is taken.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blk(input string name);
    int n;
    n = 0;
    while (!blk_valid && n < 100) begin
      tick();
      n++;
    end
    if (!blk_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: blk_valid=%b after %0d cycles, required 1", name, blk_valid, n);
    end
  endtask

  task automatic accept();
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  function automatic block_t abc_block();
    block_t b;
    b     = '0;
    b[15] = 32'h61626380;
    b[0]  = 32'h00000018;
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2;
    vectors++;
    if ({blk_valid, blk_first, blk_last, err, in_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b required 00001", {blk_valid, blk_first, blk_last, err, in_ready});
    end
    vectors++;
    if (blk_w !== 512'd0) begin
      miscompares++;
      $display("FAIL reset_blk_w: got %h required 0", blk_w);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_abc();
    block_t exp;
    exp = abc_block();
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_blk("abc");
    vectors++;
    if (blk_w !== exp) begin
      miscompares++;
      $display("FAIL abc_blk_w: got %h required %h", blk_w, exp);
    end
    vectors++;
    if ({blk_first, blk_last} !== 2'b11) begin
      miscompares++;
      $display("FAIL abc_tags: got %b required 11", {blk_first, blk_last});
    end
    accept();
    vectors++;
    if ({blk_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL abc_release: got %b required 01", {blk_valid, in_ready});
    end
  endtask

  task automatic test_empty(input string name);
    block_t exp;
    exp     = '0;
    exp[15] = 32'h80000000;
    send_word(32'hdeadbeef, 1'b1, 3'd0);
    wait_blk(name);
    vectors++;
    if (blk_w !== exp) begin
      miscompares++;
      $display("FAIL %s_blk_w: got %h required %h", name, blk_w, exp);
    end
    vectors++;
    if ({blk_first, blk_last} !== 2'b11) begin
      miscompares++;
      $display("FAIL %s_tags: got %b required 11", name, {blk_first, blk_last});
    end
    accept();
  endtask

  task automatic test_56_bytes();
    block_t exp;
    exp = '0;
    for (int i = 0; i < 14; i++) begin
      exp[15-i] = 32'ha5000000 + i;
      send_word(32'ha5000000 + i, i == 13, 3'd4);
    end
    exp[1] = 32'h80000000;
    wait_blk("b56_1");
    vectors++;
    if (blk_w !== exp) begin
      miscompares++;
      $display("FAIL b56_blk1: got %h required %h", blk_w, exp);
    end
    vectors++;
    if ({blk_first, blk_last} !== 2'b10) begin
      miscompares++;
      $display("FAIL b56_tags1: got %b required 10", {blk_first, blk_last});
    end
    accept();
    exp    = '0;
    exp[0] = 32'h000001c0;
    wait_blk("b56_2");
    vectors++;
    if (blk_w !== exp) begin
      miscompares++;
      $display("FAIL b56_blk2: got %h required %h", blk_w, exp);
    end
    vectors++;
    if ({blk_first, blk_last} !== 2'b01) begin
      miscompares++;
      $display("FAIL b56_tags2: got %b required 01", {blk_first, blk_last});
    end
    accept();
  endtask

  task automatic test_backpressure();
    block_t exp;
    exp = abc_block();
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_blk("bp");
    in_valid = 1'b1;
    in_data  = 32'h61626300;
    in_last  = 1'b1;
    in_bytes = 3'd3;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({blk_valid, in_ready, blk_first, blk_last} !== 4'b1011 || blk_w !== exp) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v/r/f/l=%b w=%h required 1011 w=%h", c,
                 {blk_valid, in_ready, blk_first, blk_last}, blk_w, exp);
      end
      tick();
    end
    accept();
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_blk("bp_next");
    vectors++;
    if (blk_w !== exp || {blk_first, blk_last} !== 2'b11) begin
      miscompares++;
      $display("FAIL bp_next: got f/l=%b w=%h required 11 w=%h", {blk_first, blk_last}, blk_w, exp);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    block_t exp;
    exp = abc_block();
    for (int i = 0; i < 7; i++) send_word(32'h11110000 + i, 1'b0, 3'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({blk_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_mid_ctl: got %b required 01", {blk_valid, in_ready});
    end
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_blk("rst_mid");
    vectors++;
    if (blk_w !== exp || {blk_first, blk_last} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_abc: got f/l=%b w=%h required 11 w=%h", {blk_first, blk_last}, blk_w, exp);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    test_abc();
    test_empty("b2b_empty");
  endtask

  // Oversized in_bytes is treated as a full word; err flags it only when checking is built.
  task automatic test_oversize();
    block_t exp;
    logic   exp_err;
`ifdef SHA_PAD_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    exp     = '0;
    exp[15] = 32'h11223344;
    exp[14] = 32'h80000000;
    exp[0]  = 32'h00000020;
    send_word(32'h11223344, 1'b1, 3'd6);
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL ovs_err: got %b required %b", err, exp_err);
    end
    wait_blk("ovs");
    vectors++;
    if (blk_w !== exp || {blk_first, blk_last} !== 2'b11) begin
      miscompares++;
      $display("FAIL ovs_blk: got f/l=%b w=%h required 11 w=%h", {blk_first, blk_last}, blk_w, exp);
    end
    accept();
    tick();
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL ovs_err_sticky: got %b required %b", err, exp_err);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty("empty");
    test_56_bytes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_oversize();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
